pulse_peak_detector: RTL and testbench
======================================

# pulse_peak_detector

Consumes the signed sample stream produced by any `vN_filter` instance and extracts per-pulse parameters: peak amplitude, peak timestamp, width above threshold and a pile-up flag. It emits one result strobe per detected pulse. It sits downstream of the filter bank in `filter` and is the reading end of the filtered-signal path that `exp_sig_gen` drives. It is used to score filter variants against the known `test_overlay`, `test_rate` and `test_delay` stimulus.

## Interface

Parameters:
- DATA_W, 16: filter sample width, signed two's complement; matches SIZE_FILTER_DATA.
- TIME_W, 16: timestamp counter width.
- WIDTH_W, 8: pulse-width counter width.
- HOLDOFF, 4: dead cycles after a pulse ends, before the block re-arms (≥1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  detection enable.
- input_data  in  DATA_W  signed filter output, one sample per cycle.
- threshold  in  DATA_W  signed detection level; compared every cycle.
- peak_valid  out  1  one-cycle result strobe.
- peak_amplitude  out  DATA_W  signed maximum sample of the pulse.
- peak_time  out  TIME_W  timestamp of the first sample equal to the maximum.
- pulse_width  out  WIDTH_W  number of samples above threshold, saturating.
- pile_up  out  1  set when the pulse had more than one local maximum.
- pulse_count  out  16  reported pulses since reset; wraps.
- busy  out  1  high in RISING, FALLING and HOLDOFF.

## Operation

- Input register: d ← input_data; d_prev ← d. The timestamp counter ts increments every cycle and wraps at 2^TIME_W. The sample presented in cycle c (cycle 0 is the first cycle after reset deasserts) carries timestamp c mod 2^TIME_W.
- All compares are signed. "Above" means d > threshold (strict).
- FSM states: IDLE, ARMED, RISING, FALLING, HOLDOFF.
  - IDLE: go to ARMED when enable=1.
  - ARMED: if d above → RISING. Load max=d, tmax=ts(d), width=1, pu=0.
  - RISING: if d ≤ threshold → END. Otherwise width+1 (saturate at 2^WIDTH_W−1). If d > max, update max and tmax. If d < d_prev → FALLING.
  - FALLING: if d ≤ threshold → END. Otherwise width+1. If d > d_prev: set pu=1, go to RISING, and update max/tmax if d > max.
  - END is an action, not a state. Register peak_amplitude=max, peak_time=tmax, pulse_width=width, pile_up=pu; pulse_count+1; peak_valid=1 for the next cycle; go to HOLDOFF.
  - HOLDOFF: count HOLDOFF cycles, then go to ARMED. Input is ignored throughout.
- Priority:
  - reset overrides everything.
  - enable=0 sends any state to IDLE at the next edge. The pulse in progress is discarded: no strobe, no count change.
  - The threshold-exit condition has priority over the pile-up re-rise.
- Equal samples (d == d_prev) do not change the RISING/FALLING state. Ties on max keep the earliest tmax.
- Result outputs hold their values until the next END; only peak_valid is a strobe.

## Timing

- Reset values: peak_valid=0, peak_amplitude=0, peak_time=0, pulse_width=0, pile_up=0, pulse_count=0, busy=0, ts=0, state IDLE.
- Latency: if the first sample at or below threshold is presented in cycle c, peak_valid is high in cycle c+2 only.
- Re-arm after HOLDOFF:
  - Samples presented in cycles c+1 … c+HOLDOFF are ignored.
  - A sample above threshold presented in cycle c+HOLDOFF+1 starts a new pulse.
- Arming: enable rising in cycle e means the sample presented in cycle e+1 is the first one eligible.
- Reset asserted mid-pulse: on the next edge all outputs take their reset values and no strobe is produced.
- A pulse never ends on its own; it ends only when a sample falls to or below threshold, enable drops, or reset asserts. The width counter saturates and does not wrap.

## Test plan

- Single pulse, threshold=100, samples 0,50,150,300,200,120,80,0 presented in cycles 10–17:
  - peak_valid only in cycle 18.
  - amplitude=300, time=13, width=4, pile_up=0, pulse_count=1.
- Pile-up, threshold=100, samples 150,300,200,250,400,120,50 from cycle 20:
  - amplitude=400, time=24, width=6, pile_up=1.
  - strobe in cycle 28.
- Holdoff, HOLDOFF=4, pulse ends at c=30 (first low sample):
  - a pulse presented in cycles 31–34 is never reported.
  - an identical pulse starting at cycle 35 is reported.
- Saturation, WIDTH_W=8, constant 500 above threshold=100 for 300 cycles starting at cycle 5:
  - width=255, amplitude=500, time=5.
- Abort:
  - enable=0 mid-pulse → no peak_valid, pulse_count unchanged, busy=0 after the next edge.
  - Repeat with reset=1 mid-pulse → every output 0 the next cycle.
- Wrap, TIME_W=4: pulse peak presented in cycle 19 → peak_time=3.

Source files
------------

// File: rtl/pulse_peak_detector.sv
// Per-pulse parameter extraction on a signed filtered sample stream:
// peak amplitude, peak timestamp, width above threshold and pile-up flag.
module pulse_peak_detector #(
  parameter int DATA_W  = 16,
  parameter int TIME_W  = 16,
  parameter int WIDTH_W = 8,
  parameter int HOLDOFF = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amplitude,
  output logic [TIME_W-1:0]        peak_time,
  output logic [WIDTH_W-1:0]       pulse_width,
  output logic                     pile_up,
  output logic [15:0]              pulse_count,
  output logic                     busy
);

  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1'b1);
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = {WIDTH_W{1'b1}};
  localparam logic [TIME_W-1:0]  TS_ONE    = TIME_W'(1'b1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    RISING    = 3'd2,
    FALLING   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic signed [DATA_W-1:0] d, d_prev, max_val, max_next;
  logic [TIME_W-1:0]        ts, d_ts, tmax, tmax_next;
  logic [WIDTH_W-1:0]       width, width_next, width_inc;
  logic [CNT_W-1:0]         hold_cnt, hold_next;
  logic                     pu, pu_next, from_idle, end_pulse, above;

  assign above     = (d > threshold);
  assign width_inc = (width == WIDTH_MAX) ? width : width + WIDTH_ONE;

  // Next-state and pulse-accumulator update from the registered sample
  always_comb begin
    state_next = state;
    max_next   = max_val;
    tmax_next  = tmax;
    width_next = width;
    pu_next    = pu;
    hold_next  = hold_cnt;
    end_pulse  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = ARMED;
        end
        // The sample captured while still in IDLE predates arming and is skipped
        ARMED: begin
          if (!from_idle && above) begin
            state_next = RISING;
            max_next   = d;
            tmax_next  = d_ts;
            width_next = WIDTH_ONE;
            pu_next    = 1'b0;
          end else begin
            state_next = ARMED;
          end
        end
        RISING: begin
          if (!above) begin
            end_pulse = 1'b1;
          end else begin
            width_next = width_inc;
            if (d > max_val) begin
              max_next  = d;
              tmax_next = d_ts;
            end else begin
              max_next  = max_val;
            end
            if (d < d_prev) begin
              state_next = FALLING;
            end else begin
              state_next = RISING;
            end
          end
        end
        FALLING: begin
          if (!above) begin
            end_pulse = 1'b1;
          end else begin
            width_next = width_inc;
            if (d > d_prev) begin
              pu_next    = 1'b1;
              state_next = RISING;
              if (d > max_val) begin
                max_next  = d;
                tmax_next = d_ts;
              end else begin
                max_next  = max_val;
              end
            end else begin
              state_next = FALLING;
            end
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = ARMED;
          end else begin
            hold_next = hold_cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
    if (end_pulse) begin
      state_next = S_HOLDOFF;
      hold_next  = '0;
    end else begin
      hold_next  = hold_next;
    end
  end

  // Input pipeline, timestamp, FSM state and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      d              <= '0;
      d_prev         <= '0;
      ts             <= '0;
      d_ts           <= '0;
      from_idle      <= 1'b0;
      state          <= IDLE;
      max_val        <= '0;
      tmax           <= '0;
      width          <= '0;
      pu             <= 1'b0;
      hold_cnt       <= '0;
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      pulse_width    <= '0;
      pile_up        <= 1'b0;
      pulse_count    <= 16'd0;
      busy           <= 1'b0;
    end else begin
      d          <= input_data;
      d_prev     <= d;
      ts         <= ts + TS_ONE;
      d_ts       <= ts;
      from_idle  <= (state == IDLE);
      state      <= state_next;
      max_val    <= max_next;
      tmax       <= tmax_next;
      width      <= width_next;
      pu         <= pu_next;
      hold_cnt   <= hold_next;
      peak_valid <= end_pulse;
      busy       <= (state_next == RISING) || (state_next == FALLING) ||
                    (state_next == S_HOLDOFF);
      if (end_pulse) begin
        peak_amplitude <= max_val;
        peak_time      <= tmax;
        pulse_width    <= width;
        pile_up        <= pu;
        pulse_count    <= pulse_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed and randomized bench for pulse_peak_detector against a
// pulse-segmentation reference model.
module tb_pulse_peak_detector;

  localparam int H = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] input_data = 16'sd0;
  logic signed [15:0] threshold = 16'sd100;

  logic               peak_valid, pile_up, busy;
  logic signed [15:0] peak_amplitude;
  logic [15:0]        peak_time, pulse_count;
  logic [7:0]         pulse_width;

  logic               w_peak_valid, w_pile_up, w_busy;
  logic signed [15:0] w_peak_amplitude;
  logic [3:0]         w_peak_time;
  logic [15:0]        w_pulse_count;
  logic [7:0]         w_pulse_width;

  pulse_peak_detector #(.DATA_W(16), .TIME_W(16), .WIDTH_W(8), .HOLDOFF(H)) dut (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data),
    .threshold(threshold), .peak_valid(peak_valid), .peak_amplitude(peak_amplitude),
    .peak_time(peak_time), .pulse_width(pulse_width), .pile_up(pile_up),
    .pulse_count(pulse_count), .busy(busy));

  pulse_peak_detector #(.DATA_W(16), .TIME_W(4), .WIDTH_W(8), .HOLDOFF(H)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .input_data(input_data),
    .threshold(threshold), .peak_valid(w_peak_valid), .peak_amplitude(w_peak_amplitude),
    .peak_time(w_peak_time), .pulse_width(w_pulse_width), .pile_up(w_pile_up),
    .pulse_count(w_pulse_count), .busy(w_busy));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected outputs for the cycle following each edge
  bit  started = 1'b0;
  int  e_valid, e_amp, e_time, e_width, e_pu, e_count, e_busy;
  int  m_cyc, hold_until, q_t0;
  bit  en1, en2, in_p, seen_dec;
  logic signed [15:0] m_smp;
  logic signed [15:0] q[$];
  logic signed [15:0] best;
  int  bi;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        started = 1'b1;
        e_valid = 0; e_amp = 0; e_time = 0; e_width = 0; e_pu = 0; e_count = 0; e_busy = 0;
        m_cyc = 0; hold_until = -1; en1 = 0; en2 = 0; in_p = 0; m_smp = 16'sd0;
        q.delete();
      end else begin
        e_valid = 0;
        if (!enable) begin
          in_p = 0; q.delete(); hold_until = -1;
        end else if (in_p) begin
          if (m_smp <= threshold) begin
            best = q[0]; bi = 0; seen_dec = 0; e_pu = 0;
            for (int i = 1; i < q.size(); i++) begin
              if (q[i] > best) begin best = q[i]; bi = i; end
              if (q[i] < q[i-1]) seen_dec = 1;
              else if (q[i] > q[i-1] && seen_dec) e_pu = 1;
            end
            e_amp = best;
            e_time = q_t0 + bi;
            e_width = (q.size() > 255) ? 255 : q.size();
            e_count = (e_count + 1) & 16'hFFFF;
            e_valid = 1;
            hold_until = m_cyc + H;
            in_p = 0; q.delete();
          end else begin
            q.push_back(m_smp);
          end
        end else if (en1 && en2 && m_cyc > hold_until && m_smp > threshold) begin
          in_p = 1; q.push_back(m_smp); q_t0 = m_cyc - 1;
        end
        e_busy = (enable && (in_p || (m_cyc + 1 <= hold_until))) ? 1 : 0;
        en2 = en1; en1 = enable; m_smp = input_data; m_cyc++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("peak_valid", peak_valid, e_valid);
        chk("peak_amplitude", peak_amplitude, e_amp);
        chk("peak_time", peak_time, e_time & 16'hFFFF);
        chk("pulse_width", pulse_width, e_width);
        chk("pile_up", pile_up, e_pu);
        chk("pulse_count", pulse_count, e_count);
        chk("busy", busy, e_busy);
        chk("wrap_peak_time", w_peak_time, e_time & 4'hF);
      end
    end
  end

  int st_d[2048];
  bit st_en[2048];
  int l_valid[2048], l_amp[2048], l_time[2048], l_width[2048], l_pu[2048];
  int l_cnt[2048], l_busy[2048], l_wtime[2048], m_amp[2048], m_time[2048], m_pu[2048];

  task automatic clear_stim();
    for (int k = 0; k < 2048; k++) begin st_d[k] = 0; st_en[k] = 1'b1; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; enable = 1'b0; input_data = 16'sd0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      input_data = 16'(st_d[k]);
      enable = st_en[k];
      l_valid[k] = int'(peak_valid); l_amp[k] = int'(peak_amplitude);
      l_time[k] = int'(peak_time); l_width[k] = int'(pulse_width);
      l_pu[k] = int'(pile_up); l_cnt[k] = int'(pulse_count); l_busy[k] = int'(busy);
      l_wtime[k] = int'(w_peak_time);
      m_amp[k] = e_amp; m_time[k] = e_time; m_pu[k] = e_pu;
    end
  endtask

  function automatic int count_valid(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += l_valid[k];
    return c;
  endfunction

  int rnd_off;

  initial begin
    // Single pulse
    threshold = 16'sd100; clear_stim();
    st_d[10] = 0; st_d[11] = 50; st_d[12] = 150; st_d[13] = 300;
    st_d[14] = 200; st_d[15] = 120; st_d[16] = 80; st_d[17] = 0;
    do_reset();
    chk("reset_count", pulse_count, 0);
    chk("reset_busy", busy, 0);
    run_phase(25);
    chk("single_strobe_18", l_valid[18], 1);
    chk("single_strobe_once", count_valid(25), 1);
    chk("single_amp", l_amp[18], 300);
    chk("single_time", l_time[18], 13);
    chk("single_width", l_width[18], 4);
    chk("single_pu", l_pu[18], 0);
    chk("single_count", l_cnt[18], 1);
    chk("model_single_amp", m_amp[18], 300);
    chk("model_single_time", m_time[18], 13);

    // Pile-up
    clear_stim();
    st_d[20] = 150; st_d[21] = 300; st_d[22] = 200; st_d[23] = 250;
    st_d[24] = 400; st_d[25] = 120; st_d[26] = 50;
    do_reset(); run_phase(32);
    chk("pile_no_early", l_valid[27], 0);
    chk("pile_strobe_28", l_valid[28], 1);
    chk("pile_amp", l_amp[28], 400);
    chk("pile_time", l_time[28], 24);
    chk("pile_width", l_width[28], 6);
    chk("pile_pu", l_pu[28], 1);
    chk("model_pile_pu", m_pu[28], 1);

    // Holdoff: pulse at 31..34 ignored, pulse at 35.. reported
    clear_stim();
    for (int k = 27; k < 30; k++) st_d[k] = 200;
    for (int k = 31; k < 35; k++) st_d[k] = 250;
    for (int k = 35; k < 39; k++) st_d[k] = 200;
    do_reset(); run_phase(45);
    chk("hold_first_strobe", l_valid[32], 1);
    chk("hold_first_width", l_width[32], 3);
    chk("hold_second_strobe", l_valid[41], 1);
    chk("hold_second_amp", l_amp[41], 200);
    chk("hold_second_time", l_time[41], 35);
    chk("hold_second_width", l_width[41], 4);
    chk("hold_strobes", count_valid(45), 2);

    // Width saturation
    clear_stim();
    for (int k = 5; k < 305; k++) st_d[k] = 500;
    do_reset(); run_phase(310);
    chk("sat_strobe", l_valid[307], 1);
    chk("sat_width", l_width[307], 255);
    chk("sat_amp", l_amp[307], 500);
    chk("sat_time", l_time[307], 5);

    // Abort by enable drop
    clear_stim();
    for (int k = 10; k < 20; k++) st_d[k] = 300;
    for (int k = 14; k < 20; k++) st_en[k] = 1'b0;
    do_reset(); run_phase(20);
    chk("abort_busy_before", l_busy[14], 1);
    chk("abort_busy_after", l_busy[15], 0);
    chk("abort_no_strobe", count_valid(20), 0);
    chk("abort_count", l_cnt[19], 0);

    // Abort by reset mid-pulse after one completed pulse
    clear_stim();
    for (int k = 5; k < 8; k++) st_d[k] = 150;
    for (int k = 14; k < 20; k++) st_d[k] = 300;
    do_reset(); run_phase(20);
    chk("rst_pre_count", l_cnt[19], 1);
    chk("rst_pre_busy", l_busy[19], 1);
    do_reset();
    chk("rst_valid", peak_valid, 0);
    chk("rst_amp", peak_amplitude, 0);
    chk("rst_time", peak_time, 0);
    chk("rst_width", pulse_width, 0);
    chk("rst_pu", pile_up, 0);
    chk("rst_count", pulse_count, 0);
    chk("rst_busy", busy, 0);

    // Timestamp wrap on the 4-bit instance
    clear_stim();
    st_d[18] = 150; st_d[19] = 300; st_d[20] = 150;
    do_reset(); run_phase(25);
    chk("wrap_strobe", l_valid[23], 1);
    chk("wrap_time_full", l_time[23], 19);
    chk("wrap_time_4b", l_wtime[23], 3);

    // Randomized stream with occasional enable drops
    clear_stim();
    threshold = 16'(int'($urandom_range(0, 8)) * 25 - 50);
    rnd_off = 0;
    for (int k = 0; k < 1500; k++) begin
      st_d[k] = int'($urandom_range(0, 28)) * 25 - 200;
      if (rnd_off > 0) begin st_en[k] = 1'b0; rnd_off--; end
      else if (k > 4 && $urandom_range(0, 59) == 0) begin
        st_en[k] = 1'b0; rnd_off = int'($urandom_range(0, 3));
      end
    end
    do_reset(); run_phase(1500);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
